// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses pll_rst, waits for lock, qualifies stability.
// Define PLL_SUP_RETRY_COUNT_EN to build the saturating retry counter.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 32,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1000
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       req_reset,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] retry_count
);

  localparam logic [1:0] S_RESET  = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_STABLE = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STB_LAST = 16'(STABLE_CYCLES - 1);

  logic        sync1_q;
  logic        locked_s_q;
  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        pll_rst_q;
  logic        sys_rst_n_q;
  logic        ready_q;

  always_comb begin
    state_d = state_q;
    if (req_reset) begin
      state_d = S_RESET;
    end else begin
      unique case (1'b1)
        state_q == S_RESET: begin
          if (cnt_q == RST_LAST) state_d = S_WAIT;
        end
        state_q == S_WAIT: begin
          // lock beats a coincident timeout
          if (locked_s_q) state_d = S_STABLE;
          else if (cnt_q == TO_LAST) state_d = S_RESET;
        end
        state_q == S_STABLE: begin
          if (!locked_s_q) state_d = S_WAIT;
          else if (cnt_q == STB_LAST) state_d = S_RUN;
        end
        state_q == S_RUN: begin
          if (!locked_s_q) state_d = S_WAIT;
        end
      endcase
    end
  end

  // a forced re-reset counts as a fresh entry even from RESET_PLL
  assign cnt_d = (req_reset || (state_d != state_q)) ? 16'd0
                                                      : cnt_q + 16'd1;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      locked_s_q  <= 1'b0;
      state_q     <= S_RESET;
      cnt_q       <= 16'd0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      sync1_q     <= pll_locked;
      locked_s_q  <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= (state_d == S_RESET);
      sys_rst_n_q <= (state_d == S_RUN);
      ready_q     <= (state_d == S_RUN);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign state     = state_q;

`ifdef PLL_SUP_RETRY_COUNT_EN
  logic [7:0] retry_q;
  logic       retry_inc;

  assign retry_inc = !req_reset && !locked_s_q &&
                     ((state_q == S_RUN) ||
                      ((state_q == S_WAIT) && (cnt_q == TO_LAST)));

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= 8'd0;
    end else if (retry_inc && (retry_q != 8'hFF)) begin
      retry_q <= retry_q + 8'd1;
    end
  end

  assign retry_count = retry_q;
`else
  assign retry_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus
// randomized lock/reset activity against a behavioural model.
module tb_pll_lock_supervisor;

  localparam int RC = 32;
  localparam int TO = 100;
  localparam int SC = 1000;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       req_reset = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [1:0] state;
  logic [7:0] retry_count;

  int n_checks = 0;
  int n_fail = 0;
  int ev = 0;

  pll_lock_supervisor #(
    .RST_CYCLES(RC),
    .LOCK_TIMEOUT(TO),
    .STABLE_CYCLES(SC)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .req_reset(req_reset),
    .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n),
    .ready(ready),
    .state(state),
    .retry_count(retry_count)
  );

  always #10 refclk = ~refclk;

  // Behavioural model: phase number, cycles spent in phase, two-sample
  // history of pll_locked standing in for the synchronizer.
  int m_phase = 0;
  int m_age = 0;
  int m_retries = 0;
  bit h_sync = 0;
  bit h_ls = 0;
  int m_nxt;
  bit m_bump;

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_age = 0; m_retries = 0; h_sync = 0; h_ls = 0;
    end else begin
      m_nxt = m_phase;
      m_bump = 0;
      if (req_reset) m_nxt = 0;
      else if (m_phase == 0) begin
        if (m_age + 1 >= RC) m_nxt = 1;
      end else if (m_phase == 1) begin
        if (h_ls) m_nxt = 2;
        else if (m_age + 1 >= TO) begin m_nxt = 0; m_bump = 1; end
      end else if (m_phase == 2) begin
        if (!h_ls) m_nxt = 1;
        else if (m_age + 1 >= SC) m_nxt = 3;
      end else if (!h_ls) begin
        m_nxt = 1; m_bump = 1;
      end
      m_age = (req_reset || m_nxt != m_phase) ? 0 : m_age + 1;
      m_phase = m_nxt;
      if (m_bump && m_retries < 255) m_retries++;
      h_ls = h_sync;
      h_sync = pll_locked;
    end
  end

  function automatic int exp_retry(input int events);
`ifdef PLL_SUP_RETRY_COUNT_EN
    return (events > 255) ? 255 : events;
`else
    return 0;
`endif
  endfunction

  task automatic wait_state(input logic [1:0] s, input int budget,
                            output int n);
    n = 0;
    while (state !== s && n < budget) begin
      @(negedge refclk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b1; req_reset = 1'b0;
    repeat (4) @(negedge refclk);
    n_checks++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_checks++;
    if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
    n_checks++;
    if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_sys_rst_n: got %b want 0", sys_rst_n); end
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_checks++;
    if (retry_count !== 8'd0) begin n_fail++; $display("FAIL reset_retry: got %0d want 0", retry_count); end
  endtask

  task automatic test_lock_sequence();
    int n;
    pll_locked = 1'b0;
    rst_n = 1'b1;
    n = 0;
    while (pll_rst === 1'b1 && n < 200) begin @(negedge refclk); n++; end
    n_checks++;
    if (n != RC) begin n_fail++; $display("FAIL rst_pulse_len: got %0d want %0d", n, RC); end
    n_checks++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL wait_entry: got %0d want 1", state); end
    pll_locked = 1'b1;
    n = 0;
    while (sys_rst_n !== 1'b1 && n < 5000) begin @(negedge refclk); n++; end
    n_checks++;
    if (n != 3 + SC) begin n_fail++; $display("FAIL release_latency: got %0d want %0d", n, 3 + SC); end
    n_checks++;
    if (state !== 2'd3 || ready !== 1'b1 || pll_rst !== 1'b0) begin
      n_fail++; $display("FAIL run_outputs: got st=%0d rdy=%b prst=%b want 3 1 0", state, ready, pll_rst);
    end
  endtask

  task automatic test_run_drop();
    int n;
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    n = 1;
    while (sys_rst_n !== 1'b0 && n < 10) begin @(negedge refclk); n++; end
    ev++;
    n_checks++;
    if (n != 3) begin n_fail++; $display("FAIL drop_to_sysrst: got %0d want 3", n); end
    n_checks++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL drop_state: got %0d want 1", state); end
    n_checks++;
    if (retry_count !== 8'(exp_retry(ev))) begin
      n_fail++; $display("FAIL drop_retry: got %0d want %0d", retry_count, exp_retry(ev));
    end
    n = 0;
    while (sys_rst_n !== 1'b1 && n < 3000) begin @(negedge refclk); n++; end
    n_checks++;
    if (n != 1 + SC) begin n_fail++; $display("FAIL relock_latency: got %0d want %0d", n, 1 + SC); end
  endtask

  task automatic test_req_reset_and_glitch();
    int n;
    req_reset = 1'b1;
    @(negedge refclk);
    req_reset = 1'b0;
    n_checks++;
    if (state !== 2'd0 || pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || ready !== 1'b0) begin
      n_fail++; $display("FAIL req_reset_outputs: got st=%0d prst=%b srst=%b rdy=%b want 0 1 0 0",
                         state, pll_rst, sys_rst_n, ready);
    end
    n_checks++;
    if (retry_count !== 8'(exp_retry(ev))) begin
      n_fail++; $display("FAIL req_reset_retry: got %0d want %0d", retry_count, exp_retry(ev));
    end
    wait_state(2'd2, 200, n);
    n_checks++;
    if (n != RC + 1) begin n_fail++; $display("FAIL rereset_to_stable: got %0d want %0d", n, RC + 1); end
    repeat (500) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    n = 1;
    while (state !== 2'd1 && n < 10) begin @(negedge refclk); n++; end
    n_checks++;
    if (n != 3) begin n_fail++; $display("FAIL glitch_to_wait: got %0d want 3", n); end
    n_checks++;
    if (retry_count !== 8'(exp_retry(ev))) begin
      n_fail++; $display("FAIL glitch_retry: got %0d want %0d", retry_count, exp_retry(ev));
    end
    wait_state(2'd2, 10, n);
    n_checks++;
    if (n != 1) begin n_fail++; $display("FAIL glitch_restable: got %0d want 1", n); end
    wait_state(2'd3, 2000, n);
    n_checks++;
    if (n != SC) begin n_fail++; $display("FAIL stable_restart: got %0d want %0d", n, SC); end
  endtask

  task automatic test_timeout();
    int n;
    int n2;
    pll_locked = 1'b0;
    wait_state(2'd1, 10, n);
    ev++;
    n_checks++;
    if (n != 3) begin n_fail++; $display("FAIL loss_to_wait: got %0d want 3", n); end
    wait_state(2'd0, 200, n);
    ev++;
    n_checks++;
    if (n != TO || retry_count !== 8'(exp_retry(ev))) begin
      n_fail++; $display("FAIL first_timeout: got n=%0d r=%0d want %0d %0d", n, retry_count, TO, exp_retry(ev));
    end
    for (int k = 0; k < 3; k++) begin
      wait_state(2'd1, 200, n);
      wait_state(2'd0, 200, n2);
      ev++;
      n_checks++;
      if (n + n2 != RC + TO || retry_count !== 8'(exp_retry(ev))) begin
        n_fail++; $display("FAIL retry_period: got p=%0d r=%0d want %0d %0d", n + n2, retry_count, RC + TO, exp_retry(ev));
      end
    end
  endtask

  task automatic test_saturation();
    int n;
    int n2;
    for (int k = 0; k < 300; k++) begin
      wait_state(2'd1, RC + 5, n);
      wait_state(2'd0, TO + 5, n2);
      ev++;
      n_checks++;
      if (n != RC || n2 != TO || retry_count !== 8'(exp_retry(ev))) begin
        n_fail++; $display("FAIL saturation_step: got n=%0d/%0d r=%0d want %0d/%0d %0d",
                           n, n2, retry_count, RC, TO, exp_retry(ev));
      end
    end
    n_checks++;
`ifdef PLL_SUP_RETRY_COUNT_EN
    if (retry_count !== 8'd255) begin n_fail++; $display("FAIL saturated: got %0d want 255", retry_count); end
`else
    if (retry_count !== 8'd0) begin n_fail++; $display("FAIL retry_disabled: got %0d want 0", retry_count); end
`endif
  endtask

  task automatic test_async_reset();
    int n;
    pll_locked = 1'b1;
    wait_state(2'd3, RC + TO + SC + 50, n);
    n_checks++;
    if (n >= RC + TO + SC + 50) begin n_fail++; $display("FAIL reach_run: got timeout want state 3"); end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sys_rst_n !== 1'b0 || pll_rst !== 1'b1 || state !== 2'd0 || ready !== 1'b0 || retry_count !== 8'd0) begin
      n_fail++; $display("FAIL async_reset: got srst=%b prst=%b st=%0d rdy=%b r=%0d want 0 1 0 0 0",
                         sys_rst_n, pll_rst, state, ready, retry_count);
    end
    ev = 0;
    @(negedge refclk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [12:0] got;
    logic [12:0] want;
    int r;
    int errs;
    errs = 0;
    for (int i = 0; i < 12000; i++) begin
      @(negedge refclk);
      got = {state, pll_rst, sys_rst_n, ready, retry_count};
      want = {2'(m_phase), m_phase == 0, m_phase == 3, m_phase == 3,
              8'(exp_retry(m_retries))};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        if (errs < 10) $display("FAIL random_cycle %0d: got %h want %h", i, got, want);
        errs++;
      end
      r = int'($urandom_range(0, 9999));
      req_reset = (r < 6);
      if (!rst_n) rst_n = 1'b1;
      else if (r == 9999) rst_n = 1'b0;
      if (pll_locked) begin
        if (r >= 100 && r < 108) pll_locked = 1'b0;
      end else if (r >= 100 && r < 250) begin
        pll_locked = 1'b1;
      end
    end
    req_reset = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_run_drop();
    test_req_reset_and_glitch();
    test_timeout();
    test_saturation();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 32, refclk cycles pll_rst is held high per reset pulse (range 1..65535).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000, refclk cycles allowed in WAIT_LOCK before retrying (1 ms at 50 MHz).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1000, consecutive locked cycles required before release (range 1..65535).
REQ-004 refclk  input  1  free-running 50 MHz reference; the single clock of this block.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 pll_locked  input  1  PLL locked flag, asynchronous to refclk.
REQ-007 req_reset  input  1  synchronous single-cycle request to re-reset the PLL.
REQ-008 pll_rst  output  1  active-high reset to the PLL rst input.
REQ-009 sys_rst_n  output  1  active-low system reset for logic on PLL output clocks.
REQ-010 ready  output  1  high only in state RUN.
REQ-011 state  output  2  encoding: 0=RESET_PLL, 1=WAIT_LOCK, 2=STABLE, 3=RUN.
REQ-012 retry_count  output  8  count of timeouts plus lock losses (see Configuration).

Function
REQ-013 pll_locked SHALL pass through a 2-flop synchronizer; all decisions use only the synchronized value locked_s.
REQ-014 One 16-bit counter SHALL be cleared on every state entry and increment once per cycle within the state.
REQ-015 RESET_PLL: pll_rst=1; after RST_CYCLES cycles in the state, go to WAIT_LOCK.
REQ-016 WAIT_LOCK: pll_rst=0; if locked_s=1, go to STABLE.
REQ-017 WAIT_LOCK: if the counter reaches LOCK_TIMEOUT-1 with locked_s=0, go to RESET_PLL and increment retry_count.
REQ-018 STABLE: if locked_s=0, go to WAIT_LOCK with no retry increment.
REQ-019 STABLE: after STABLE_CYCLES consecutive cycles with locked_s=1, go to RUN.
REQ-020 RUN: if locked_s=0, go to WAIT_LOCK and increment retry_count.
REQ-021 req_reset=1 SHALL force RESET_PLL from any state and takes priority over every other transition.
REQ-022 If timeout and locked_s=1 occur in the same WAIT_LOCK cycle, lock wins: go to STABLE.
REQ-023 Outputs SHALL be registered; sys_rst_n=1 and ready=1 exactly when state=RUN.
REQ-024 sys_rst_n SHALL go low on the first refclk edge after locked_s falls in RUN; worst case is 3 refclk cycles after pll_locked falls.
REQ-025 From pll_locked rising in WAIT_LOCK, sys_rst_n SHALL rise after 2 synchronizer cycles, then 1 cycle to enter STABLE, then STABLE_CYCLES cycles.
REQ-026 retry_count SHALL saturate at 255 and never wrap.

Reset
REQ-027 While rst_n=0, SHALL hold: state=RESET_PLL, pll_rst=1, sys_rst_n=0, ready=0, counter=0, synchronizer=0, retry_count=0.
REQ-028 Reset assertion SHALL be asynchronous; deassertion is seen on the next refclk edge, which begins a full RST_CYCLES pulse.
REQ-029 Reset mid-operation, including in RUN, SHALL immediately drop sys_rst_n and raise pll_rst.

Configuration
REQ-030 Macro PLL_SUP_RETRY_COUNT_EN defined: retry_count operates per REQ-017, REQ-020 and REQ-026.
REQ-031 Macro PLL_SUP_RETRY_COUNT_EN undefined: retry_count is tied to 0 and its counter logic is omitted; all other behaviour is identical.

Verification
REQ-032 Release rst_n with pll_locked=1 and defaults -> pll_rst high 32 cycles, then WAIT_LOCK; sys_rst_n rises 1003 cycles after WAIT_LOCK entry.
REQ-033 Hold pll_locked=0 with LOCK_TIMEOUT=100 -> RESET_PLL re-entered every 132 cycles; retry_count=1,2,3 after each timeout.
REQ-034 In RUN, drop pll_locked for 1 cycle -> sys_rst_n low within 3 cycles, state=WAIT_LOCK, retry_count+1; relock gives RUN after STABLE_CYCLES again.
REQ-035 In STABLE at counter=500, glitch pll_locked low -> WAIT_LOCK, retry_count unchanged, stable count restarts from 0.
REQ-036 Pulse req_reset in RUN -> next cycle state=RESET_PLL, pll_rst=1, sys_rst_n=0; no retry increment.
REQ-037 Force 300 lock losses -> retry_count holds at 255; with macro undefined, retry_count stays 0 throughout.
